// File: rtl/ecs_bit_unstuffer.sv
// rtl/ecs_bit_unstuffer.sv - ECS byte-to-bit unstuffer with 0xFF00 removal and RST/EOI marker detection
module ecs_bit_unstuffer #(
    parameter logic RST_SEQ_CHECK = 1'b1
) (
    input  logic       i_sysclk,
    input  logic       i_arstn,
    input  logic       i_srst,
    input  logic       i_byte_en,
    input  logic [7:0] i_byte,
    output logic       o_byte_ready,
    input  logic       i_bit_re,
    output logic       o_scan_en,
    output logic       o_ecs_bit,
    input  logic       i_resync,
    output logic       o_rst_marker,
    output logic       o_eoi,
    output logic       o_err
);

    logic [7:0] la_q, la_d;
    logic       la_v_q, la_v_d;
    logic       la_ff_q, la_ff_d;
    logic [7:0] sh_q, sh_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] seq_q, seq_d;
    logic       rst_marker_q, rst_marker_d;
    logic       eoi_q, eoi_d;
    logic       err_q, err_d;

    logic halt, byte_ready, accept, consume, load;

    assign halt       = rst_marker_q | eoi_q | err_q;
    assign byte_ready = ~halt & (~la_v_q | la_ff_q);
    assign accept     = i_byte_en & byte_ready;
    assign consume    = (cnt_q != 4'd0) & i_bit_re;
    // Refill on the last bit's consume so consecutive bytes stream without a bubble.
    assign load       = la_v_q & ~la_ff_q & ((cnt_q == 4'd0) | ((cnt_q == 4'd1) & consume));

    always_comb begin
        la_d         = la_q;
        la_v_d       = la_v_q;
        la_ff_d      = la_ff_q;
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        seq_d        = seq_q;
        rst_marker_d = rst_marker_q;
        eoi_d        = eoi_q;
        err_d        = err_q;

        if (consume) begin
            sh_d  = {sh_q[6:0], 1'b0};
            cnt_d = cnt_q - 4'd1;
        end
        if (load) begin
            sh_d   = la_q;
            cnt_d  = 4'd8;
            la_v_d = 1'b0;
        end

        if (accept) begin
            if (la_v_q && la_ff_q) begin
                case (i_byte)
                    8'h00: la_ff_d = 1'b0;
                    8'hFF: begin
                    end
                    8'hD9: begin
                        la_v_d  = 1'b0;
                        la_ff_d = 1'b0;
                        eoi_d   = 1'b1;
                    end
                    default: begin
                        la_v_d  = 1'b0;
                        la_ff_d = 1'b0;
                        if (i_byte[7:3] == 5'b11010) begin
                            rst_marker_d = 1'b1;
                            if (RST_SEQ_CHECK && (i_byte[2:0] != seq_q))
                                err_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                endcase
            end else begin
                la_d    = i_byte;
                la_v_d  = 1'b1;
                la_ff_d = (i_byte == 8'hFF);
            end
        end

        // Restart boundary drops any leftover padding bits.
        if (i_resync && rst_marker_q) begin
            cnt_d        = 4'd0;
            rst_marker_d = 1'b0;
            seq_d        = seq_q + 3'd1;
        end

        if (i_srst) begin
            la_v_d       = 1'b0;
            la_ff_d      = 1'b0;
            sh_d         = 8'h00;
            cnt_d        = 4'd0;
            seq_d        = 3'd0;
            rst_marker_d = 1'b0;
            eoi_d        = 1'b0;
            err_d        = 1'b0;
        end
    end

    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            la_q         <= 8'h00;
            la_v_q       <= 1'b0;
            la_ff_q      <= 1'b0;
            sh_q         <= 8'h00;
            cnt_q        <= 4'd0;
            seq_q        <= 3'd0;
            rst_marker_q <= 1'b0;
            eoi_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            la_q         <= la_d;
            la_v_q       <= la_v_d;
            la_ff_q      <= la_ff_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            seq_q        <= seq_d;
            rst_marker_q <= rst_marker_d;
            eoi_q        <= eoi_d;
            err_q        <= err_d;
        end
    end

    assign o_byte_ready = byte_ready;
    assign o_scan_en    = (cnt_q != 4'd0);
    assign o_ecs_bit    = sh_q[7];
    assign o_rst_marker = rst_marker_q;
    assign o_eoi        = eoi_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_ecs_bit_unstuffer.sv
// tb/tb_ecs_bit_unstuffer.sv - self-checking bench for ecs_bit_unstuffer
module tb_ecs_bit_unstuffer;

    logic       i_sysclk = 1'b0;
    logic       i_arstn;
    logic       i_srst;
    logic       i_byte_en;
    logic [7:0] i_byte;
    logic       o_byte_ready;
    logic       i_bit_re;
    logic       o_scan_en;
    logic       o_ecs_bit;
    logic       i_resync;
    logic       o_rst_marker;
    logic       o_eoi;
    logic       o_err;

    always #5 i_sysclk = ~i_sysclk;

    ecs_bit_unstuffer #(.RST_SEQ_CHECK(1'b1)) dut (
        .i_sysclk    (i_sysclk),
        .i_arstn     (i_arstn),
        .i_srst      (i_srst),
        .i_byte_en   (i_byte_en),
        .i_byte      (i_byte),
        .o_byte_ready(o_byte_ready),
        .i_bit_re    (i_bit_re),
        .o_scan_en   (o_scan_en),
        .o_ecs_bit   (o_ecs_bit),
        .i_resync    (i_resync),
        .o_rst_marker(o_rst_marker),
        .o_eoi       (o_eoi),
        .o_err       (o_err)
    );

    int   n_chk = 0;
    int   n_fail = 0;
    logic exp_q[$];
    int   budget = -1;
    int   cyc = 0;
    int   n_pop = 0;
    int   first_pop = -1;
    int   last_pop = -1;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] d0;
        logic [7:0] d1;
        int         nd;
        logic       rm;
        logic       eoi;
        logic       err;
        logic       rdy;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) exp_q.push_back(b[i]);
    endtask

    // Consumer: decides i_bit_re for the coming edge and scores the bit it takes.
    always begin
        @(negedge i_sysclk);
        #1;
        cyc++;
        i_bit_re = (budget != 0);
        if (o_scan_en && i_bit_re && i_arstn) begin
            if (exp_q.size() == 0) begin
                chk("bit_extra", 1, 0);
            end else begin
                chk("bit", o_ecs_bit, exp_q.pop_front());
            end
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            n_pop++;
            if (budget > 0) budget--;
        end
    end

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        i_byte_en = 1'b1;
        i_byte    = b;
        while (!o_byte_ready && t < 100) begin
            @(negedge i_sysclk);
            t++;
        end
        if (t >= 100) chk("send_timeout", 0, 1);
        @(posedge i_sysclk);
        @(negedge i_sysclk);
        i_byte_en = 1'b0;
    endtask

    task automatic do_srst();
        i_srst = 1'b1;
        @(negedge i_sysclk);
        i_srst = 1'b0;
        exp_q.delete();
        n_pop = 0;
        first_pop = -1;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge i_sysclk);
            t++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic wait_budget(input string name);
        int t;
        t = 0;
        while (budget != 0 && t < 200) begin
            @(negedge i_sysclk);
            t++;
        end
        chk(name, budget, 0);
    endtask

    task automatic run_s1();
        n_pop = 0;
        first_pop = -1;
        budget = -1;
        push_bits(8'hA5, 8);
        push_bits(8'h3C, 8);
        send(8'hA5);
        chk("s1_lat0", o_scan_en, 0);
        @(negedge i_sysclk);
        chk("s1_lat1", o_scan_en, 1);
        send(8'h3C);
        wait_drain("s1_drain");
        chk("s1_npop", n_pop, 16);
        chk("s1_nogap", last_pop - first_pop, 15);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h12, 8'h34, 8'h12, 8'h34, 2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'hD0, 8'h00, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8'hD5, 8'h00, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 8'hD9, 8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'h01, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'hC0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1, 1'b0};

        i_arstn   = 1'b0;
        i_srst    = 1'b0;
        i_byte_en = 1'b0;
        i_byte    = 8'h00;
        i_bit_re  = 1'b0;
        i_resync  = 1'b0;
        repeat (3) @(negedge i_sysclk);
        chk("rst_ready", o_byte_ready, 1);
        chk("rst_scan_en", o_scan_en, 0);
        chk("rst_bit", o_ecs_bit, 0);
        chk("rst_marker", o_rst_marker, 0);
        chk("rst_eoi", o_eoi, 0);
        chk("rst_err", o_err, 0);
        i_arstn = 1'b1;
        @(negedge i_sysclk);

        run_s1();

        do_srst();
        push_bits(8'hFF, 8);
        push_bits(8'h12, 8);
        send(8'hFF);
        send(8'h00);
        send(8'h12);
        wait_drain("s2_drain");
        chk("s2_npop", n_pop, 16);
        chk("s2_err", o_err, 0);
        i_resync = 1'b1;
        @(negedge i_sysclk);
        i_resync = 1'b0;
        send(8'hFF);
        send(8'hD0);
        chk("s2_idle_resync_marker", o_rst_marker, 1);
        chk("s2_idle_resync_err", o_err, 0);

        do_srst();
        budget = 5;
        push_bits(8'h8F, 5);
        send(8'h8F);
        send(8'hFF);
        send(8'hD0);
        wait_budget("s3_budget");
        chk("s3_marker", o_rst_marker, 1);
        chk("s3_pad_valid", o_scan_en, 1);
        chk("s3_pad_bit", o_ecs_bit, 1);
        chk("s3_ready", o_byte_ready, 0);
        chk("s3_err", o_err, 0);
        i_resync = 1'b1;
        @(negedge i_sysclk);
        i_resync = 1'b0;
        chk("s3_post_scan_en", o_scan_en, 0);
        chk("s3_post_marker", o_rst_marker, 0);
        chk("s3_post_ready", o_byte_ready, 1);
        budget = -1;
        push_bits(8'h00, 8);
        send(8'h00);
        send(8'hFF);
        send(8'hD1);
        wait_drain("s3_drain");
        chk("s3_rst1_marker", o_rst_marker, 1);
        chk("s3_rst1_err", o_err, 0);

        do_srst();
        send(8'hFF);
        send(8'hD3);
        chk("s4_marker", o_rst_marker, 1);
        chk("s4_err", o_err, 1);
        chk("s4_ready", o_byte_ready, 0);
        do_srst();
        chk("s4_clr_marker", o_rst_marker, 0);
        chk("s4_clr_err", o_err, 0);
        chk("s4_clr_eoi", o_eoi, 0);
        chk("s4_clr_ready", o_byte_ready, 1);

        do_srst();
        budget = 4;
        push_bits(8'h55, 8);
        send(8'h55);
        send(8'hFF);
        send(8'hFF);
        send(8'hD9);
        wait_budget("s5_budget");
        chk("s5_eoi", o_eoi, 1);
        chk("s5_ready", o_byte_ready, 0);
        chk("s5_err", o_err, 0);
        for (int k = 0; k < 3; k++) begin
            chk("s5_stall_valid", o_scan_en, 1);
            chk("s5_stall_bit", o_ecs_bit, 0);
            @(negedge i_sysclk);
        end
        budget = -1;
        wait_drain("s5_drain");
        repeat (3) @(negedge i_sysclk);
        chk("s5_npop", n_pop, 8);
        chk("s5_empty", o_scan_en, 0);
        chk("s5_eoi_hold", o_eoi, 1);
        chk("s5_ready_hold", o_byte_ready, 0);
        do_srst();
        chk("s5_clr_eoi", o_eoi, 0);

        for (int i = 0; i < 7; i++) begin
            do_srst();
            budget = -1;
            if (vecs[i].nd >= 1) push_bits(vecs[i].d0, 8);
            if (vecs[i].nd >= 2) push_bits(vecs[i].d1, 8);
            send(vecs[i].b0);
            send(vecs[i].b1);
            wait_drain($sformatf("v%0d_drain", i));
            repeat (2) @(negedge i_sysclk);
            chk($sformatf("v%0d_marker", i), o_rst_marker, vecs[i].rm);
            chk($sformatf("v%0d_eoi", i), o_eoi, vecs[i].eoi);
            chk($sformatf("v%0d_err", i), o_err, vecs[i].err);
            chk($sformatf("v%0d_ready", i), o_byte_ready, vecs[i].rdy);
            chk($sformatf("v%0d_npop", i), n_pop, vecs[i].nd * 8);
        end

        do_srst();
        budget = 4;
        push_bits(8'hA5, 4);
        send(8'hA5);
        send(8'hFF);
        send(8'hD9);
        wait_budget("s6_budget");
        chk("s6_pre_eoi", o_eoi, 1);
        chk("s6_pre_valid", o_scan_en, 1);
        #2;
        i_arstn = 1'b0;
        #1;
        chk("s6_arst_scan_en", o_scan_en, 0);
        chk("s6_arst_marker", o_rst_marker, 0);
        chk("s6_arst_eoi", o_eoi, 0);
        chk("s6_arst_err", o_err, 0);
        chk("s6_arst_ready", o_byte_ready, 1);
        exp_q.delete();
        @(negedge i_sysclk);
        i_arstn = 1'b1;
        @(negedge i_sysclk);
        run_s1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ecs_bit_unstuffer.md
# ecs_bit_unstuffer

Converts the entropy-coded-segment byte stream after an SOS header into the serial bit stream that `entropy_decoder` consumes on its `i_scan_en`/`i_ecs_bit` inputs. It sits between the byte source and `entropy_decoder`. It performs three jobs:
- removes 0xFF00 byte stuffing;
- detects RSTn and EOI markers, and discards the padding bits before a restart;
- applies back-pressure both upstream and to the bit consumer.

## Interface
- `RST_SEQ_CHECK`, default 1. When 1, an RSTn marker whose n is not the expected value raises `o_err`.
- `i_sysclk`, in, 1: system clock. All logic uses the rising edge.
- `i_arstn`, in, 1: asynchronous, active-low reset.
- `i_srst`, in, 1: synchronous clear at scan start. Driven from the parser's `o_sos_start`.
- `i_byte_en`, in, 1: `i_byte` is valid.
- `i_byte`, in, 8: ECS byte.
- `o_byte_ready`, out, 1: byte accepted on a cycle where `i_byte_en && o_byte_ready`.
- `i_bit_re`, in, 1: consumer takes `o_ecs_bit` this cycle. Driven from `entropy_decoder` `o_ed_ready`.
- `o_scan_en`, out, 1: `o_ecs_bit` is valid.
- `o_ecs_bit`, out, 1: current bit, MSB of the byte first.
- `i_resync`, in, 1: one-cycle pulse. The consumer has reached a restart-interval boundary.
- `o_rst_marker`, out, 1: level. An RSTn marker is pending and the block is halted.
- `o_eoi`, out, 1: level. EOI (0xFFD9) seen. Sticky until `i_srst`.
- `o_err`, out, 1: level. Illegal marker or wrong RST sequence. Sticky until `i_srst`.

## Operation
**Storage**
- Lookahead register `la` (8 b) with flags `la_v` and `la_ff`.
- Shifter `sh` (8 b) with count `cnt` (0..8).
- Expected RST index `seq` (3 b).
- `halt = o_rst_marker | o_eoi | o_err`.

**Byte input**
- `o_byte_ready = ~halt & (~la_v | la_ff)`.
- Accepted byte with `la_v=0`:
  - If the byte is 0xFF: `la ← FF`, `la_v ← 1`, `la_ff ← 1`.
  - Otherwise: `la ← byte`, `la_v ← 1`, `la_ff ← 0`.
- Accepted byte with `la_ff=1`, depending on the byte:
  - 0x00: `la_ff ← 0`. `la` now holds data 0xFF.
  - 0xFF: fill byte. State unchanged.
  - 0xD0–0xD7: `la_v ← 0`, `o_rst_marker ← 1`. If `RST_SEQ_CHECK` and `byte[2:0] ≠ seq`, also `o_err ← 1`.
  - 0xD9: `la_v ← 0`, `o_eoi ← 1`.
  - Any other value: `la_v ← 0`, `o_err ← 1`.

**Shifter**
- `o_scan_en = (cnt ≠ 0)`.
- `o_ecs_bit = sh[7]`.
- Consume happens when `o_scan_en & i_bit_re`: `sh ← sh << 1`, `cnt ← cnt − 1`.
- Load happens when `la_v & ~la_ff` and (`cnt = 0`, or `cnt = 1` with a consume this cycle): `sh ← la`, `cnt ← 8`, `la_v ← 0`. There is no bubble between bytes.
- Byte input and a load may occur in the same cycle. The new byte goes into the freed `la`.

**Restart**
- While `o_rst_marker` is high, the remaining shifter bits (the padding) are still presented, but the consumer is not required to take them.
- `i_resync` while `o_rst_marker = 1`, applied on the next edge: `cnt ← 0`, `o_rst_marker ← 0`, `seq ← seq + 1` (mod 8).
- `i_resync` while `o_rst_marker = 0` is ignored.

**Clear and priority**
- `i_srst` clears all state: `la_v`, `la_ff`, `cnt`, `seq`, `o_rst_marker`, `o_eoi`, `o_err`.
- Priority, highest first: `i_arstn`, then `i_srst`, then `i_resync`, then load/consume.
- `o_eoi` and `o_err` do not flush the shifter. Remaining bits can still be consumed.

## Timing
- Reset values: `o_byte_ready = 1` (it follows from `halt = 0` and `la_v = 0`). `o_scan_en`, `o_ecs_bit`, `o_rst_marker`, `o_eoi` and `o_err` are all 0.
- Latency: a byte accepted at edge N, with the shifter empty, gives `o_scan_en = 1` after edge N+1. A data 0xFF is visible after edge N+1, where N is the edge that accepted its 0x00.
- Throughput: 1 bit per cycle sustained while `i_bit_re = 1` and a byte arrives at least every 8 cycles.
- `o_ecs_bit` holds while `i_bit_re = 0`.
- Marker flags assert on the edge that accepts the second marker byte. `o_byte_ready` drops in the same cycle the flag rises.
- After `i_resync`, the cycle that follows has `o_scan_en = 0` and `o_byte_ready = 1`.

## Test plan
1. Bytes A5, 3C back-to-back, `i_bit_re = 1` → 16 consecutive valid bits 1010_0101_0011_1100. First valid bit 1 cycle after the A5 accept, no gap between the two bytes.
2. Bytes FF, 00, 12 → bits 1111_1111_0001_0010. No zero byte emitted, `o_err = 0`.
3. Bytes 8F, FF, D0; consumer takes 5 bits then idles → `o_rst_marker = 1`, `o_scan_en = 1` with bit 1 (3 padding bits left), `o_byte_ready = 0`. Pulse `i_resync` → next cycle `o_scan_en = 0`, `o_rst_marker = 0`, `o_byte_ready = 1`. Then 00, FF, D1 → `o_rst_marker = 1`, `o_err = 0`.
4. After reset, bytes FF, D3 → `o_rst_marker = 1`, `o_err = 1`, `o_byte_ready = 0`. `i_srst` → all flags 0 and `o_byte_ready = 1`.
5. Bytes 55, FF, FF, D9 with a consumer stall of 3 cycles mid-byte → `o_ecs_bit` stable during the stall, all 8 bits of 55 delivered, fill byte dropped, `o_eoi = 1`, `o_byte_ready = 0` until `i_srst`.
6. `i_arstn` low while `cnt = 4` → `o_scan_en` and all flags 0 immediately, no clock edge needed. After release, the next byte behaves as in scenario 1.
